// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared pipeline-control types and constants for mini_cpu
//   state_e : control FSM states
//   ctrl_t  : packed bundle of PC enable plus per-stage valid/flush pairs
package cpu_ctrl_pkg;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;
   typedef struct packed {
      logic pc_en;
      logic if_id_valid;
      logic if_id_flush;
      logic id_ex_valid;
      logic id_ex_flush;
      logic ex_mem_valid;
      logic ex_mem_flush;
      logic mem_wb_valid;
      logic mem_wb_flush;
   } ctrl_t;
   localparam ctrl_t CTRL_OFF  = 9'b0_00_00_00_00;
   localparam ctrl_t CTRL_RUN  = 9'b1_10_10_10_10;
   // Upstream registers hold; MEM/WB takes a bubble so the waiting access is not written back twice.
   localparam ctrl_t CTRL_MW   = 9'b0_00_00_00_01;
   localparam ctrl_t CTRL_BR   = 9'b1_01_01_10_10;
   localparam ctrl_t CTRL_LU   = 9'b0_00_01_10_10;
   localparam ctrl_t CTRL_FW   = 9'b0_01_10_10_10;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs and stage-control outputs between pipeline and controller
//   master : the hazard controller (drives pc_en and valid/flush pairs)
//   slave  : the pipeline datapath (drives register ids and hazard status)
interface pipe_hazard_ctrl_if;
   import cpu_ctrl_pkg::*;
   logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_noflush, ex_branch_taken;
   logic mem_req, mem_ready, if_ready;
   logic pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush;
   logic ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush;
   modport master (
      input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_noflush,
             ex_branch_taken, mem_req, mem_ready, if_ready,
      output pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
             ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush
   );
   modport slave (
      output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_noflush,
             ex_branch_taken, mem_req, mem_ready, if_ready,
      input  pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
             ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush
   );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator
//   inputs  : ID source registers and use bits, EX destination, EX load/live flags
//   load_use: ID instruction needs the result of the live load in EX
module hazard_detect
   import cpu_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_noflush,
   output logic                  load_use
);
   assign load_use = ex_mem_read & ex_noflush & (ex_rd != REG_X0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller with data-memory timeout
//   clk, reset   : clock, asynchronous active-high reset
//   pif          : hazard inputs in, PC enable and per-stage valid/flush out
//   mem_err      : sticky data-memory timeout flag
//   stall_cycles : saturating count of stalled (pc_en=0) non-halted cycles
module pipe_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               reset,
   pipe_hazard_ctrl_if.master pif,
   output logic               mem_err,
   output logic [CNT_W-1:0]   stall_cycles
);
   localparam int TW = $clog2(MEM_TIMEOUT);
   state_e           state_q, state_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use, mw, br;
   ctrl_t            ctrl;
   hazard_detect u_hazard_detect (
      .id_rs1      (pif.id_rs1),
      .id_rs2      (pif.id_rs2),
      .id_uses_rs1 (pif.id_uses_rs1),
      .id_uses_rs2 (pif.id_uses_rs2),
      .ex_rd       (pif.ex_rd),
      .ex_mem_read (pif.ex_mem_read),
      .ex_noflush  (pif.ex_noflush),
      .load_use    (load_use)
   );
   assign mw = pif.mem_req & ~pif.mem_ready;
   assign br = pif.ex_branch_taken & pif.ex_noflush;
   // Reset gates the outputs combinationally so the pipeline freezes the moment reset rises.
   assign ctrl = (reset || state_q == HALT) ? CTRL_OFF :
                 mw                         ? CTRL_MW  :
                 br                         ? CTRL_BR  :
                 load_use                   ? CTRL_LU  :
                 !pif.if_ready              ? CTRL_FW  : CTRL_RUN;
   assign pif.pc_en        = ctrl.pc_en;
   assign pif.if_id_valid  = ctrl.if_id_valid;
   assign pif.if_id_flush  = ctrl.if_id_flush;
   assign pif.id_ex_valid  = ctrl.id_ex_valid;
   assign pif.id_ex_flush  = ctrl.id_ex_flush;
   assign pif.ex_mem_valid = ctrl.ex_mem_valid;
   assign pif.ex_mem_flush = ctrl.ex_mem_flush;
   assign pif.mem_wb_valid = ctrl.mem_wb_valid;
   assign pif.mem_wb_flush = ctrl.mem_wb_flush;
   assign mem_err          = err_q;
   assign stall_cycles     = stall_q;
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      if (state_q == RUN && mw) begin
         state_d = MEM_WAIT;
         tmo_d   = TW'(1);
      end else if (state_q == MEM_WAIT) begin
         // Leaving on either completion or a dropped request (external flush).
         if (!mw) begin
            state_d = RUN;
            tmo_d   = '0;
         end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
            state_d = HALT;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      stall_d = (!ctrl.pc_en && state_q != HALT && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end
endmodule
